// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin value codes, strobe
// bit order and FSM state encodings. The coin input encoder uses the same codes.
package change_dispenser_pkg;

    // Each coin code is the binary coin value. Subtracting the code from an
    // amount therefore removes exactly that many NT$.
    localparam logic [3:0] COIN_1  = 4'b0001;
    localparam logic [3:0] COIN_2  = 4'b0010;
    localparam logic [3:0] COIN_5  = 4'b0101;
    localparam logic [3:0] COIN_10 = 4'b1010;

    // Strobe vector bit order: {ten, five, two, one}
    localparam int STB_ONE  = 0;
    localparam int STB_TWO  = 1;
    localparam int STB_FIVE = 2;
    localparam int STB_TEN  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_EJECT  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // One-hot strobe vector for a coin code. Any code that is not a coin gives 0.
    function automatic logic [3:0] coin_strobe(input logic [3:0] code);
        logic [3:0] s;
        s = 4'b0000;
        case (code)
            COIN_1:  s[STB_ONE]  = 1'b1;
            COIN_2:  s[STB_TWO]  = 1'b1;
            COIN_5:  s[STB_FIVE] = 1'b1;
            COIN_10: s[STB_TEN]  = 1'b1;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker: returns the largest coin not exceeding the amount
// still owed (priority 10 > 5 > 2 > 1). Returns code 0000 when nothing is owed.
module change_coin_select
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] remaining,
    output logic [3:0]       code,
    output logic [3:0]       strobes
);

    // Priority compare against the coin values, largest coin first
    always_comb begin
        code = 4'b0000;
        if (remaining >= AMT_W'(10))
            code = COIN_10;
        else if (remaining >= AMT_W'(5))
            code = COIN_5;
        else if (remaining >= AMT_W'(2))
            code = COIN_2;
        else if (remaining >= AMT_W'(1))
            code = COIN_1;
        strobes = coin_strobe(code);
    end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return sequencer. Takes a change amount and ejects it greedily, one
// coin per handshake with the coin ejector.
// Handshake: coin_valid rises with a stable coin_code/strobes and stays up,
// unchanged, until a rising edge where coin_ready is high. That edge transfers
// the coin. coin_valid never drops without a transfer except on abort or reset.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int AMT_W   = 8,
    parameter int GAP_CYC = 2,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             abort,
    input  logic             coin_ready,
    output logic             coin_valid,
    output logic [3:0]       coin_code,
    output logic             one,
    output logic             two,
    output logic             five,
    output logic             ten,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] coins_out,
    output logic [2:0]       dbg_state
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_e            state, state_nxt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [3:0]        strobes;
    logic [3:0]        sel_code;
    logic [3:0]        sel_strobes;
    logic              accept;

    assign accept = (state == ST_EJECT) && coin_ready;

    change_coin_select #(.AMT_W(AMT_W)) u_select (
        .remaining (remaining),
        .code      (sel_code),
        .strobes   (sel_strobes)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. Abort returns any busy state to IDLE. In EJECT an
    // abort on the same edge as coin_ready still lets the coin count.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SELECT;
            ST_SELECT: begin
                if (abort)                state_nxt = ST_IDLE;
                else if (remaining == '0) state_nxt = ST_DONE;
                else                      state_nxt = ST_EJECT;
            end
            ST_EJECT: begin
                if (abort)              state_nxt = ST_IDLE;
                else if (coin_ready)    state_nxt = (GAP_CYC > 0) ? ST_GAP : ST_SELECT;
            end
            ST_GAP: begin
                if (abort)                   state_nxt = ST_IDLE;
                else if (gap_cnt == GAP_LAST) state_nxt = ST_SELECT;
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: amount latch, coin presentation, counters and the gap timer
    always_ff @(posedge clk) begin
        if (rst) begin
            remaining  <= '0;
            coins_out  <= '0;
            coin_valid <= 1'b0;
            coin_code  <= 4'b0000;
            strobes    <= 4'b0000;
            gap_cnt    <= '0;
        end else begin
            gap_cnt <= (state == ST_GAP) ? gap_cnt + GAP_W'(1) : '0;
            if (state == ST_IDLE && start) begin
                remaining <= amount;
                coins_out <= '0;
            end
            if (state == ST_SELECT && !abort && remaining != '0) begin
                coin_valid <= 1'b1;
                coin_code  <= sel_code;
                strobes    <= sel_strobes;
            end
            if (accept) begin
                remaining  <= remaining - AMT_W'(coin_code);
                if (coins_out != '1)
                    coins_out <= coins_out + CNT_W'(1);
                coin_valid <= 1'b0;
                coin_code  <= 4'b0000;
                strobes    <= 4'b0000;
            end
            if (abort && state != ST_IDLE) begin
                remaining  <= '0;
                coin_valid <= 1'b0;
                coin_code  <= 4'b0000;
                strobes    <= 4'b0000;
            end
        end
    end

    assign one       = strobes[STB_ONE];
    assign two       = strobes[STB_TWO];
    assign five      = strobes[STB_FIVE];
    assign ten       = strobes[STB_TEN];
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

endmodule
